// File: rtl/fsk_bit_decoder.sv
// ---------------------------------------------------------------------------
// fsk_bit_decoder
// Frames one bit period per window on top of an FSK frequency analyzer:
// clears the analyzer, lets it integrate, then compares the f0/f1 tick totals
// to decide the bit. Decided bits are packed LSB-first into words that are
// handed out on a valid/ready handshake, with a sticky overrun flag when a
// completed word has nowhere to go.
// ---------------------------------------------------------------------------
module fsk_bit_decoder #(
    parameter int CLOCK_FREQUENCY  = 50000000,
    parameter int BIT_RATE         = 1000,
    parameter int MIN_FILL_PERCENT = 25,
    parameter int BITS_PER_WORD    = 8
) (
    input  logic                     clock_i,
    input  logic                     clear_i,
    input  logic                     enable_i,
    input  logic [31:0]              f0_value_i,
    input  logic [31:0]              f1_value_i,
    output logic                     analyzer_clear_o,
    output logic                     analyzer_enable_o,
    output logic                     bit_value_o,
    output logic                     bit_valid_o,
    output logic                     bit_error_o,
    output logic [BITS_PER_WORD-1:0] word_o,
    output logic                     word_valid_o,
    input  logic                     word_ready_i,
    output logic                     overrun_o
);

    localparam int          BIT_TICKS  = CLOCK_FREQUENCY / BIT_RATE;
    // INTEGRATE spans BIT_TICKS-2 cycles with the tick counter starting at 0.
    localparam logic [31:0] LAST_TICK  = 32'(BIT_TICKS - 3);
    localparam logic [63:0] FILL_LIMIT = 64'(MIN_FILL_PERCENT) * 64'(BIT_TICKS);
    localparam logic [5:0]  WORD_BITS  = 6'(BITS_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RESTART   = 2'd1,
        ST_INTEGRATE = 2'd2,
        ST_DECIDE    = 2'd3
    } state_t;

    state_t                   state_q;
    logic [31:0]              tick_q;
    logic [5:0]               bit_count_q;
    logic [BITS_PER_WORD-1:0] assembly_q;
    logic                     analyzer_clear_q;
    logic                     analyzer_enable_q;
    logic                     bit_value_q;
    logic                     bit_valid_q;
    logic                     bit_error_q;
    logic [BITS_PER_WORD-1:0] word_q;
    logic                     word_valid_q;
    logic                     overrun_q;

    logic [32:0]              sum_s;
    logic                     fill_ok_s;
    logic                     bit_ok_s;
    logic                     bit_s;
    logic [BITS_PER_WORD-1:0] mask_s;
    logic [BITS_PER_WORD-1:0] assembled_d;
    logic                     word_done_s;

    // Bit decision and word assembly candidates from the current analyzer totals.
    always_comb begin
        sum_s       = {1'b0, f0_value_i} + {1'b0, f1_value_i};
        fill_ok_s   = ((64'(sum_s) * 64'd100) >= FILL_LIMIT);
        bit_ok_s    = fill_ok_s && (f0_value_i != f1_value_i);
        bit_s       = (f1_value_i > f0_value_i);
        mask_s      = BITS_PER_WORD'(1'b1) << bit_count_q;
        if (bit_s) begin
            assembled_d = assembly_q | mask_s;
        end else begin
            assembled_d = assembly_q;
        end
        word_done_s = ((bit_count_q + 6'd1) == WORD_BITS);
    end

    // Window sequencer, bit decision register, word handoff and overrun tracking.
    always_ff @(posedge clock_i) begin
        if (!clear_i) begin
            state_q           <= ST_IDLE;
            tick_q            <= 32'd0;
            bit_count_q       <= 6'd0;
            assembly_q        <= '0;
            analyzer_clear_q  <= 1'b0;
            analyzer_enable_q <= 1'b0;
            bit_value_q       <= 1'b0;
            bit_valid_q       <= 1'b0;
            bit_error_q       <= 1'b0;
            word_q            <= '0;
            word_valid_q      <= 1'b0;
            overrun_q         <= 1'b0;
        end else begin
            // Pulses last one cycle unless a decision re-raises them below.
            bit_valid_q <= 1'b0;
            bit_error_q <= 1'b0;
            // An accepted word retires; a word loaded this same cycle overrides this.
            if (word_valid_q && word_ready_i) begin
                word_valid_q <= 1'b0;
            end
            if (!enable_i) begin
                // Abort: drop the partial word, keep anything already offered.
                state_q           <= ST_IDLE;
                tick_q            <= 32'd0;
                bit_count_q       <= 6'd0;
                assembly_q        <= '0;
                analyzer_clear_q  <= 1'b0;
                analyzer_enable_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q           <= ST_RESTART;
                        analyzer_clear_q  <= 1'b0;
                        analyzer_enable_q <= 1'b0;
                    end
                    ST_RESTART: begin
                        state_q           <= ST_INTEGRATE;
                        tick_q            <= 32'd0;
                        analyzer_clear_q  <= 1'b1;
                        analyzer_enable_q <= 1'b1;
                    end
                    ST_INTEGRATE: begin
                        tick_q <= tick_q + 32'd1;
                        if (tick_q == LAST_TICK) begin
                            state_q           <= ST_DECIDE;
                            analyzer_clear_q  <= 1'b1;
                            analyzer_enable_q <= 1'b0;
                        end else begin
                            state_q           <= ST_INTEGRATE;
                            analyzer_clear_q  <= 1'b1;
                            analyzer_enable_q <= 1'b1;
                        end
                    end
                    ST_DECIDE: begin
                        state_q           <= ST_RESTART;
                        analyzer_clear_q  <= 1'b0;
                        analyzer_enable_q <= 1'b0;
                        if (!bit_ok_s) begin
                            bit_error_q <= 1'b1;
                            bit_count_q <= 6'd0;
                            assembly_q  <= '0;
                        end else begin
                            bit_valid_q <= 1'b1;
                            bit_value_q <= bit_s;
                            if (word_done_s) begin
                                bit_count_q <= 6'd0;
                                assembly_q  <= '0;
                                if (!word_valid_q || word_ready_i) begin
                                    word_q       <= assembled_d;
                                    word_valid_q <= 1'b1;
                                end else begin
                                    overrun_q <= 1'b1;
                                end
                            end else begin
                                bit_count_q <= bit_count_q + 6'd1;
                                assembly_q  <= assembled_d;
                            end
                        end
                    end
                    default: begin
                        state_q           <= ST_IDLE;
                        analyzer_clear_q  <= 1'b0;
                        analyzer_enable_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign analyzer_clear_o  = analyzer_clear_q;
    assign analyzer_enable_o = analyzer_enable_q;
    assign bit_value_o       = bit_value_q;
    assign bit_valid_o       = bit_valid_q;
    assign bit_error_o       = bit_error_q;
    assign word_o            = word_q;
    assign word_valid_o      = word_valid_q;
    assign overrun_o         = overrun_q;

endmodule

// File: tb/tb_fsk_bit_decoder.sv
// ---------------------------------------------------------------------------
// Bench for fsk_bit_decoder with a short bit window (BIT_TICKS = 20, fill
// threshold f0+f1 >= 5). A phase-counting reference model predicts every
// output each cycle; directed literal checks pin the model at key points.
// ---------------------------------------------------------------------------
module tb_fsk_bit_decoder;

    localparam int CF   = 20;
    localparam int BR   = 1;
    localparam int FILL = 25;
    localparam int BPW  = 8;
    localparam int BT   = CF / BR;

    logic           clk = 1'b0;
    logic           clear = 1'b0;
    logic           enable = 1'b0;
    logic [31:0]    f0 = 32'd0;
    logic [31:0]    f1 = 32'd0;
    logic           word_ready = 1'b0;
    logic           aclr, aen, bval, bvalid, berr, wvalid, ovr;
    logic [BPW-1:0] word;

    int n_tests = 0;
    int n_fail  = 0;

    fsk_bit_decoder #(
        .CLOCK_FREQUENCY (CF),
        .BIT_RATE        (BR),
        .MIN_FILL_PERCENT(FILL),
        .BITS_PER_WORD   (BPW)
    ) dut (
        .clock_i          (clk),
        .clear_i          (clear),
        .enable_i         (enable),
        .f0_value_i       (f0),
        .f1_value_i       (f1),
        .analyzer_clear_o (aclr),
        .analyzer_enable_o(aen),
        .bit_value_o      (bval),
        .bit_valid_o      (bvalid),
        .bit_error_o      (berr),
        .word_o           (word),
        .word_valid_o     (wvalid),
        .word_ready_i     (word_ready),
        .overrun_o        (ovr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_phase = cycles since the current window's restart cycle (0..BT-1).
    bit       m_armed = 1'b0;
    bit       m_run   = 1'b0;
    int       m_phase = 0;
    int       m_bits[$];
    bit       e_aclr = 1'b0, e_aen = 1'b0, e_bv = 1'b0, e_bval = 1'b0;
    bit       e_berr = 1'b0, e_wv = 1'b0, e_ovr = 1'b0;
    logic [BPW-1:0] e_word = '0;
    bit       wv_old;
    longint   sum;
    logic [BPW-1:0] w;

    always @(posedge clk) begin
        if (!clear) begin
            m_armed = 1'b1; m_run = 1'b0; m_phase = 0; m_bits.delete();
            e_aclr = 0; e_aen = 0; e_bv = 0; e_bval = 0; e_berr = 0;
            e_wv = 0; e_ovr = 0; e_word = '0;
        end else begin
            wv_old = e_wv;
            e_bv   = 0;
            e_berr = 0;
            if (e_wv && word_ready) e_wv = 0;
            if (!enable) begin
                m_run = 0;
                m_bits.delete();
            end else if (!m_run) begin
                m_run   = 1;
                m_phase = 0;
            end else if (m_phase == BT - 1) begin
                m_phase = 0;
                sum = longint'(f0) + longint'(f1);
                if (sum * 100 < longint'(FILL * BT) || f0 == f1) begin
                    e_berr = 1;
                    m_bits.delete();
                end else begin
                    e_bv   = 1;
                    e_bval = (f1 > f0);
                    m_bits.push_back(e_bval ? 1 : 0);
                    if (m_bits.size() == BPW) begin
                        w = '0;
                        for (int i = 0; i < BPW; i++) if (m_bits[i] != 0) w[i] = 1'b1;
                        m_bits.delete();
                        if (!wv_old || word_ready) begin
                            e_word = w;
                            e_wv   = 1;
                        end else begin
                            e_ovr = 1;
                        end
                    end
                end
            end else begin
                m_phase++;
            end
            e_aclr = m_run && (m_phase != 0);
            e_aen  = m_run && (m_phase >= 1) && (m_phase <= BT - 2);
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_armed) begin
            check("analyzer_clear",  32'(aclr),   32'(e_aclr));
            check("analyzer_enable", 32'(aen),    32'(e_aen));
            check("bit_valid",       32'(bvalid), 32'(e_bv));
            check("bit_error",       32'(berr),   32'(e_berr));
            check("bit_value",       32'(bval),   32'(e_bval));
            check("word_valid",      32'(wvalid), 32'(e_wv));
            check("word",            32'(word),   32'(e_word));
            check("overrun",         32'(ovr),    32'(e_ovr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_bit(input int a, input int b, output int cyc);
        f0  = 32'(a);
        f1  = 32'(b);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(bvalid || berr) && cyc < 3 * BT);
        if (!(bvalid || berr)) begin
            n_tests++;
            n_fail++;
            $display("FAIL pulse_timeout: no bit pulse after %0d cycles, expected within %0d", cyc, BT + 1);
        end
    endtask

    task automatic send_word(input logic [7:0] v);
        int c;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) send_bit(1, 16, c);
            else      send_bit(16, 1, c);
        end
    endtask

    task automatic ready_pulse();
        @(negedge clk);
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        int pulses;

        // 1: reset held with enable high
        @(negedge clk);
        clear  = 1'b0;
        enable = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_aclr",   32'(aclr),   32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_word",   32'(word),   32'd0);
        check("rst_ovr",    32'(ovr),    32'd0);

        // 2: bit decisions, latency from reset release
        clear = 1'b1;
        send_bit(2, 40, cyc);
        check("lat_first", 32'(cyc), 32'd21);
        check("bit1_valid", 32'(bvalid), 32'd1);
        check("bit1_value", 32'(bval),   32'd1);
        send_bit(40, 2, cyc);
        check("lat_next",  32'(cyc), 32'(BT));
        check("bit0_value", 32'(bval),   32'd0);

        // 3: boundary fill (sum 5 passes), empty window (sum 4), tie
        send_bit(4, 1, cyc);
        check("fill_edge_valid", 32'(bvalid), 32'd1);
        send_bit(3, 1, cyc);
        check("empty_err",   32'(berr),   32'd1);
        check("empty_valid", 32'(bvalid), 32'd0);
        send_bit(8, 8, cyc);
        check("tie_err", 32'(berr), 32'd1);

        // 4: word 0xA5 then accept one cycle later
        send_word(8'hA5);
        check("word_a5",   32'(word),   32'hA5);
        check("model_a5",  32'(e_word), 32'hA5);
        check("wv_a5",     32'(wvalid), 32'd1);
        ready_pulse();
        check("wv_accept", 32'(wvalid), 32'd0);
        check("word_kept", 32'(word),   32'hA5);

        // 5: overrun, old word retained, overrun sticky
        send_word(8'hA5);
        send_word(8'h3C);
        check("ovr_word", 32'(word),   32'hA5);
        check("ovr_flag", 32'(ovr),    32'd1);
        check("ovr_wv",   32'(wvalid), 32'd1);
        ready_pulse();
        check("ovr_wv_drop", 32'(wvalid), 32'd0);
        check("ovr_sticky",  32'(ovr),    32'd1);

        // 6: abort mid-integrate of bit 5, then a clean word from bit 0
        send_bit(1, 16, cyc);
        send_bit(1, 16, cyc);
        send_bit(1, 16, cyc);
        send_bit(1, 16, cyc);
        repeat (5) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort_aclr", 32'(aclr), 32'd0);
        check("abort_aen",  32'(aen),  32'd0);
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bvalid || berr) pulses++;
        end
        check("abort_no_pulse", 32'(pulses), 32'd0);
        enable     = 1'b1;
        word_ready = 1'b1;
        send_word(8'hC3);
        check("restart_word", 32'(word),   32'hC3);
        check("restart_wv",   32'(wvalid), 32'd1);
        @(negedge clk);
        check("restart_wv_acc", 32'(wvalid), 32'd0);
        word_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
